// File: rtl/fls_check_pkg.sv
`default_nettype none
// ============================================================================
// fls_check_pkg : shared state encoding, ALU op codes and default widths
//                 for the FLS sequence checker and generator.
// Revision      : 1.0
// ============================================================================
package fls_check_pkg;

  localparam int DEFAULT_WIDTH = 7;
  localparam int DEFAULT_LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ONE   = 2'b01,
    ST_CHECK = 2'b10,
    ST_FAIL  = 2'b11
  } fls_state_e;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;
  localparam logic [2:0] ALU_OP_AND = 3'b010;
  localparam logic [2:0] ALU_OP_OR  = 3'b011;
  localparam logic [2:0] ALU_OP_XOR = 3'b100;
  localparam logic [2:0] ALU_OP_NOT = 3'b101;
  localparam logic [2:0] ALU_OP_SHL = 3'b110;
  localparam logic [2:0] ALU_OP_SHR = 3'b111;

endpackage
`default_nettype wire

// File: rtl/fls_check_alu.sv
`default_nettype none
// ============================================================================
// alu_7 : small combinational ALU used across the FLS lab blocks.
// Revision : 1.0
// ============================================================================
module alu_7
  import fls_check_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_OP_ADD: y = a + b;
      ALU_OP_SUB: y = a - b;
      ALU_OP_AND: y = a & b;
      ALU_OP_OR:  y = a | b;
      ALU_OP_XOR: y = a ^ b;
      ALU_OP_NOT: y = ~a;
      ALU_OP_SHL: y = a << 1;
      ALU_OP_SHR: y = a >> 1;
      default:    y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule
`default_nettype wire

// File: rtl/fls_check_btn_edge.sv
`default_nettype none
// ============================================================================
// btn_edge : two-flop rising-edge detector for a raw button level.
// Revision : 1.0
// ============================================================================
module btn_edge (
  input  logic clk,
  input  logic btn,
  output logic pulse
);

  logic r1_d, r1_q;
  logic r2_d, r2_q;

  always_comb begin
    r1_d = btn;
    r2_d = r1_q;
  end

  // No reset: the edge history must survive rst so a held button cannot
  // re-trigger once reset is released.
  always_ff @(posedge clk) begin
    r1_q <= r1_d;
    r2_q <= r2_d;
  end

  assign pulse = r1_q & ~r2_q;

endmodule
`default_nettype wire

// File: rtl/fls_check.sv
`default_nettype none
// ============================================================================
// fls_check : verifies f[n] = f[n-1] + f[n-2] mod 2^WIDTH, one term per
//             button press, reporting verdict and saturating run length.
// Revision  : 1.0
// ============================================================================
module fls_check
  import fls_check_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] f,
  output logic             ok,
  output logic             err,
  output logic [LEN_W-1:0] len
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic             pulse;
  logic [WIDTH-1:0] sum;
  logic             alu_zero_unused;

  fls_state_e       state_d, state_q;
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] f_d, f_q;
  logic [LEN_W-1:0] len_d, len_q;
  logic             ok_d, ok_q;
  logic             err_d, err_q;

  btn_edge u_btn_edge (
    .clk   (clk),
    .btn   (en),
    .pulse (pulse)
  );

  alu_7 #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a    (a_q),
    .b    (b_q),
    .op   (ALU_OP_ADD),
    .y    (sum),
    .zero (alu_zero_unused)
  );

  always_comb begin
    state_d = state_q;
    if (pulse) begin
      case (state_q)
        ST_IDLE:  state_d = ST_ONE;
        ST_ONE:   state_d = ST_CHECK;
        ST_CHECK: state_d = (d == sum) ? ST_CHECK : ST_FAIL;
        default:  state_d = ST_FAIL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    f_d   = f_q;
    len_d = len_q;
    ok_d  = ok_q;
    err_d = err_q;
    if (pulse) begin
      case (state_q)
        ST_IDLE: begin
          a_d   = d;
          f_d   = d;
          len_d = LEN_W'(1);
        end
        ST_ONE: begin
          b_d   = d;
          f_d   = d;
          len_d = LEN_W'(2);
        end
        ST_CHECK: begin
          f_d = d;
          if (d == sum) begin
            a_d   = b_q;
            b_d   = d;
            len_d = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;
            ok_d  = 1'b1;
          end else begin
            err_d = 1'b1;
            ok_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      f_q   <= '0;
      len_q <= '0;
      ok_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      f_q   <= f_d;
      len_q <= len_d;
      ok_q  <= ok_d;
      err_q <= err_d;
    end
  end

  assign f   = f_q;
  assign ok  = ok_q;
  assign err = err_q;
  assign len = len_q;

endmodule
`default_nettype wire
